// File: rtl/edge_event_arbiter.sv
// Serialises 1-cycle event pulses from N sources onto a single valid/ready channel
// using sticky pending flags, round-robin grant and per-source loss tracking.
module edge_event_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    evt_in,
    output logic            event_valid,
    output logic [ID_W-1:0] event_id,
    input  logic            event_ready,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow,
    input  logic            clr_overflow,
    output logic [7:0]      drop_cnt
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr, rr_ptr_nxt, event_id_nxt;
    logic            event_valid_nxt;

    logic            handshake;
    logic [N-1:0]    hs_vec, lost, pending_nxt, overflow_nxt;
    logic [CNT_W-1:0] lost_cnt;
    logic [8:0]      drop_sum;
    logic [7:0]      drop_nxt;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;

    assign handshake = event_valid & event_ready;

    // Pending capture and loss detection; a pulse on the source being accepted is a new event.
    always_comb begin
        hs_vec   = '0;
        lost_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hs_vec[i] = handshake && (event_id == ID_W'(i));
        end
        lost        = evt_in & pending & ~hs_vec;
        pending_nxt = evt_in | (pending & ~hs_vec);
        for (int unsigned i = 0; i < N; i++) begin
            lost_cnt = lost_cnt + CNT_W'(lost[i]);
        end
        drop_sum     = clr_overflow ? 9'(lost_cnt) : 9'(drop_cnt) + 9'(lost_cnt);
        drop_nxt     = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        overflow_nxt = clr_overflow ? lost : (overflow | lost);
    end

    // Round-robin search starting at rr_ptr with explicit wrap at N.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = ID_W'(idx);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Offer FSM next-state and registered-output values.
    always_comb begin
        state_nxt       = state;
        event_valid_nxt = event_valid;
        event_id_nxt    = event_id;
        rr_ptr_nxt      = rr_ptr;
        case (state)
            IDLE: begin
                event_valid_nxt = 1'b0;
                if (grant_found) begin
                    event_id_nxt    = grant_idx;
                    event_valid_nxt = 1'b1;
                    state_nxt       = OFFER;
                end
            end
            OFFER: begin
                event_valid_nxt = 1'b1;
                if (event_ready) begin
                    event_valid_nxt = 1'b0;
                    rr_ptr_nxt      = (event_id == ID_W'(N - 1)) ? '0 : event_id + ID_W'(1);
                    state_nxt       = IDLE;
                end
            end
            default: begin
                state_nxt       = IDLE;
                event_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            event_valid <= 1'b0;
            event_id    <= '0;
            rr_ptr      <= '0;
        end else begin
            state       <= state_nxt;
            event_valid <= event_valid_nxt;
            event_id    <= event_id_nxt;
            rr_ptr      <= rr_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            drop_cnt <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed vector table plus
// hand-written reset-mid-offer and drop counter saturation sequences.
module tb_edge_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] evt_in;
    logic       event_valid;
    logic [1:0] event_id;
    logic       event_ready;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       clr_overflow;
    logic [7:0] drop_cnt;

    int n_cmp;
    int n_err;

    edge_event_arbiter #(.N(4), .ID_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .evt_in       (evt_in),
        .event_valid  (event_valid),
        .event_id     (event_id),
        .event_ready  (event_ready),
        .pending      (pending),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] evt;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [1:0] id;
        logic [3:0] p;
        logic [3:0] o;
        logic [7:0] d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [3:0] evt, logic rdy, logic clr,
                                logic v, logic [1:0] id, logic [3:0] p, logic [3:0] o,
                                logic [7:0] d);
        vec_t r;
        r.rst = rst; r.evt = evt; r.rdy = rdy; r.clr = clr;
        r.v = v; r.id = id; r.p = p; r.o = o; r.d = d;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic v, input logic [1:0] id,
                             input logic [3:0] p, input logic [3:0] o, input logic [7:0] d);
        check("event_valid", idx, 32'(event_valid), 32'(v));
        if (v) check("event_id", idx, 32'(event_id), 32'(id));
        check("pending", idx, 32'(pending), 32'(p));
        check("overflow", idx, 32'(overflow), 32'(o));
        check("drop_cnt", idx, 32'(drop_cnt), 32'(d));
    endtask

    task automatic do_reset();
        evt_in       = '0;
        event_ready  = 1'b0;
        clr_overflow = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick(input logic [3:0] evt, input logic rdy, input logic clr);
        evt_in       = evt;
        event_ready  = rdy;
        clr_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        evt_in = '0; event_ready = 1'b0; clr_overflow = 1'b0; rst_n = 1'b0;
        #12;
        check_all(-1, 1'b0, 2'd0, 4'h0, 4'h0, 8'd0);
        check("event_id_reset", -1, 32'(event_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single pulse on source 1
        vecs.push_back(mk(0, 4'b0010, 1, 0, 0, 0, 4'b0010, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 1, 4'b0010, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'h0, 0));
        // sources 0 and 2 together
        vecs.push_back(mk(1, 4'b0101, 1, 0, 0, 0, 4'b0101, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 0, 4'b0101, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0100, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 2, 4'b0100, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'h0, 0));
        // all sources re-pulsed every cycle
        vecs.push_back(mk(1, 4'b1111, 1, 0, 0, 0, 4'b1111, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0, 4'b1111, 4'hF, 4));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 4'b1111, 4'hF, 7));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 1, 4'b1111, 4'hF, 11));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 4'b1111, 4'hF, 14));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 2, 4'b1111, 4'hF, 18));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 4'b1111, 4'hF, 21));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 3, 4'b1111, 4'hF, 25));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 4'b1111, 4'hF, 28));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0, 4'b1111, 4'hF, 32));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 4'b1110, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 1, 4'b1110, 4'h0, 0));
        // backpressure, repeat pulse on 3, late higher-priority source, clear
        vecs.push_back(mk(1, 4'b1000, 0, 0, 0, 0, 4'b1000, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 3, 4'b1000, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1000, 0, 0, 1, 3, 4'b1000, 4'b1000, 1));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 1, 3, 4'b1001, 4'b1000, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 3, 4'b1001, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0001, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 0, 4'b0001, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'h0, 0));
        // re-pulse in the handshake cycle; ready while idle ignored
        vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 4'b0100, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 2, 4'b0100, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 4'b0100, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 2, 4'b0100, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'h0, 0));
        // loss in the same cycle as clear wins
        vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0011, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0011, 0, 0, 1, 0, 4'b0011, 4'b0011, 2));
        vecs.push_back(mk(0, 4'b0010, 0, 1, 1, 0, 4'b0011, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0010, 4'b0010, 1));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            tick(vecs[i].evt, vecs[i].rdy, vecs[i].clr);
            check_all(i, vecs[i].v, vecs[i].id, vecs[i].p, vecs[i].o, vecs[i].d);
        end

        // reset asserted mid-offer, between edges
        tick(4'b0000, 1'b0, 1'b0);
        check("pre_rst_valid", 100, 32'(event_valid), 32'd1);
        check("pre_rst_id", 100, 32'(event_id), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(101, 1'b0, 2'd0, 4'h0, 4'h0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(4'b0000, 1'b1, 1'b0);
            check_all(102 + k, 1'b0, 2'd0, 4'h0, 4'h0, 8'd0);
        end
        tick(4'b0010, 1'b1, 1'b0);
        check_all(105, 1'b0, 2'd0, 4'b0010, 4'h0, 8'd0);
        tick(4'b0000, 1'b1, 1'b0);
        check_all(106, 1'b1, 2'd1, 4'b0010, 4'h0, 8'd0);

        // sustained loss: 4 per cycle, saturating at 255
        do_reset();
        tick(4'b1111, 1'b0, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            tick(4'b1111, 1'b0, 1'b0);
            if (k == 63) check("drop_cnt_252", 200, 32'(drop_cnt), 32'd252);
            if (k == 64) check("drop_cnt_sat", 201, 32'(drop_cnt), 32'd255);
        end
        check("drop_cnt_held", 202, 32'(drop_cnt), 32'd255);
        check("sat_overflow", 202, 32'(overflow), 32'hF);
        check("sat_id", 202, 32'(event_id), 32'd0);
        tick(4'b0000, 1'b0, 1'b1);
        check_all(203, 1'b1, 2'd0, 4'hF, 4'h0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
